alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream command stage for the registered-operand ALU datapath (operand regs + ALU_DUT).
//  Accepts one ALU command per valid/ready handshake and drives operands, active-low load
//  enables and ALU control into the datapath. Waits for the ALU to settle, captures
//  result/carry and returns them on a valid/ready response port. One command in flight.
// PARAMETERS
//  WIDTH          4  operand/result width; must match the datapath WIDTH
//  SETTLE_CYCLES  1  cycles between operand-register load and result capture (>=1)
//  CNT_W          8  width of the saturating completed-operation counter
// PORTS
//  clk_i          in   1        single clock, all logic posedge
//  rst_i          in   1        reset, asynchronous, active-low
//  cmd_valid_i    in   1        command valid
//  cmd_ready_o    out  1        command ready (high only in IDLE)
//  cmd_op_a_i     in   WIDTH    operand A
//  cmd_op_b_i     in   WIDTH    operand B
//  cmd_alu_op_i   in   2        ALU operation (alu_op_e)
//  op_a_o         out  WIDTH    to datapath op_A
//  op_b_o         out  WIDTH    to datapath op_B
//  en_reg_a_no    out  1        to datapath en_reg_a_i, active-low load
//  en_reg_b_no    out  1        to datapath en_reg_b_i, active-low load
//  cntrl_alu_o    out  2        to datapath cntrl_alu_i
//  result_i       in   WIDTH    from datapath result_o
//  carry_i        in   1        from datapath carry_o
//  rsp_valid_o    out  1        response valid
//  rsp_ready_i    in   1        response ready
//  rsp_result_o   out  WIDTH    captured result
//  rsp_carry_o    out  1        captured carry
//  busy_o         out  1        high whenever state != IDLE
//  ops_done_o     out  CNT_W    completed responses, saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst_i=0): state IDLE; cmd_ready_o=1 after release; en_reg_*_no=1;
//   op_*_o, cntrl_alu_o, rsp_result_o, rsp_carry_o, ops_done_o = 0; rsp_valid_o=0; busy_o=0.
//  All outputs registered except cmd_ready_o and busy_o (decoded from state register).
//  FSM: IDLE -> LOAD -> SETTLE -> RESP -> IDLE.
//   IDLE:   cmd_ready_o=1. On cmd_valid_i&cmd_ready_o at edge E0: latch op_a/op_b/alu_op
//           onto op_*_o/cntrl_alu_o, drive en_reg_a_no=en_reg_b_no=0, go LOAD.
//   LOAD:   one cycle; datapath loads at edge E1. At E1 drive both enables back to 1,
//           clear settle counter, go SETTLE.
//   SETTLE: count SETTLE_CYCLES cycles; at final edge capture result_i/carry_i into
//           rsp_*_o, set rsp_valid_o=1, go RESP.
//   RESP:   hold rsp_* stable while rsp_valid_o & !rsp_ready_i. On handshake: rsp_valid_o=0,
//           ops_done_o+1 (saturating), go IDLE.
//  Latency: rsp_valid_o rises SETTLE_CYCLES+1 edges after the accepting edge E0.
//  Throughput: one op per SETTLE_CYCLES+3 cycles with rsp_ready_i held high.
//  op_*_o and cntrl_alu_o hold their value from E0 until the next accepted command.
//  Enables are low for exactly one cycle per command; never low outside LOAD.
//  cmd_valid_i outside IDLE is ignored (not accepted, no side effects).
//  Arithmetic: none internal. Result/carry are passed through unmodified; width is WIDTH.
//  ops_done_o at 2**CNT_W-1 stays there on further completions.
//  Reset mid-operation: immediate return to IDLE with reset values; the in-flight command
//   is dropped and no response is produced.
// STRUCTURE
//  alu_pkg: typedef enum logic[1:0] alu_op_e {ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10,
//   ALU_OR=2'b11}; typedef enum seq_state_e {IDLE, LOAD, SETTLE, RESP}.
//  Single module; no sub-module. Bench instantiates alu_op_sequencer + datapath top.
// TESTING
//  1 Reset: rst_i=0 mid-cycle -> all outputs at reset values asynchronously, en_reg_*_no=1.
//  2 ADD 4'h9+4'h8, rsp_ready_i=1 -> rsp_result_o=4'h1, rsp_carry_o=1, valid at E0+2 edges.
//  3 SUB 4'h3-4'h5 with rsp_ready_i=0 for 5 cycles -> rsp_* stable 5 cycles, cmd_ready_o=0.
//  4 Back-to-back AND 4'hC&4'hA then OR 4'hC|4'hA -> 4'h8 then 4'hE; enables low 1 cycle each.
//  5 Reset asserted during SETTLE -> no rsp_valid_o, ops_done_o=0, cmd_ready_o=1 after release.
//  6 CNT_W=2, 5 ops -> ops_done_o reads 1,2,3,3,3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: ALU operation codes and sequencer states.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        SETTLE = 2'b10,
        RESP   = 2'b11
    } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Command stage for the registered-operand ALU datapath: loads operands, waits for the
// ALU to settle, captures result/carry and returns them on a valid/ready response port.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_op_a_i,
    input  logic [WIDTH-1:0] cmd_op_b_i,
    input  logic [1:0]       cmd_alu_op_i,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o,
    output logic             en_reg_a_no,
    output logic             en_reg_b_no,
    output logic [1:0]       cntrl_alu_o,
    input  logic [WIDTH-1:0] result_i,
    input  logic             carry_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_carry_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] ops_done_o
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_LOAD   = LOAD;
    localparam logic [1:0] ST_SETTLE = SETTLE;
    localparam logic [1:0] ST_RESP   = RESP;

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};

    logic [1:0]          state_r;
    logic [SETTLE_W-1:0] settle_cnt_r;
    logic [WIDTH-1:0]    op_a_r;
    logic [WIDTH-1:0]    op_b_r;
    logic [1:0]          cntrl_alu_r;
    logic                en_reg_a_r;
    logic                en_reg_b_r;
    logic                rsp_valid_r;
    logic [WIDTH-1:0]    rsp_result_r;
    logic                rsp_carry_r;
    logic [CNT_W-1:0]    ops_done_r;

    // Sequencer FSM with its operand, enable, response and counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= {SETTLE_W{1'b0}};
            op_a_r       <= {WIDTH{1'b0}};
            op_b_r       <= {WIDTH{1'b0}};
            cntrl_alu_r  <= 2'b00;
            en_reg_a_r   <= 1'b1;
            en_reg_b_r   <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= {WIDTH{1'b0}};
            rsp_carry_r  <= 1'b0;
            ops_done_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        op_a_r      <= cmd_op_a_i;
                        op_b_r      <= cmd_op_b_i;
                        cntrl_alu_r <= cmd_alu_op_i;
                        en_reg_a_r  <= 1'b0;
                        en_reg_b_r  <= 1'b0;
                        state_r     <= ST_LOAD;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // Datapath registers load on this edge; enables go inactive together.
                    en_reg_a_r   <= 1'b1;
                    en_reg_b_r   <= 1'b1;
                    settle_cnt_r <= {SETTLE_W{1'b0}};
                    state_r      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        rsp_result_r <= result_i;
                        rsp_carry_r  <= carry_i;
                        rsp_valid_r  <= 1'b1;
                        state_r      <= ST_RESP;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        if (ops_done_r != CNT_MAX) begin
                            ops_done_r <= ops_done_r + CNT_W'(1);
                        end else begin
                            ops_done_r <= CNT_MAX;
                        end
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    en_reg_a_r  <= 1'b1;
                    en_reg_b_r  <= 1'b1;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o  = (state_r == ST_IDLE);
    assign busy_o       = (state_r != ST_IDLE);
    assign op_a_o       = op_a_r;
    assign op_b_o       = op_b_r;
    assign cntrl_alu_o  = cntrl_alu_r;
    assign en_reg_a_no  = en_reg_a_r;
    assign en_reg_b_no  = en_reg_b_r;
    assign rsp_valid_o  = rsp_valid_r;
    assign rsp_result_o = rsp_result_r;
    assign rsp_carry_o  = rsp_carry_r;
    assign ops_done_o   = ops_done_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural registered-operand ALU datapath;
// a second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op_a;
    logic [3:0] cmd_op_b;
    logic [1:0] cmd_alu_op;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       en_reg_a_n;
    logic       en_reg_b_n;
    logic [1:0] cntrl_alu;
    logic [3:0] dp_result;
    logic       dp_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic       busy;
    logic [7:0] ops_done;

    logic       n_cmd_ready;
    logic [3:0] n_op_a;
    logic [3:0] n_op_b;
    logic       n_en_a;
    logic       n_en_b;
    logic [1:0] n_cntrl;
    logic       n_rsp_valid;
    logic [3:0] n_rsp_result;
    logic       n_rsp_carry;
    logic       n_busy;
    logic [1:0] n_ops_done;

    logic [3:0] reg_a;
    logic [3:0] reg_b;

    int error_count;
    int check_count;

    alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_a_i(cmd_op_a), .cmd_op_b_i(cmd_op_b), .cmd_alu_op_i(cmd_alu_op),
        .op_a_o(op_a), .op_b_o(op_b),
        .en_reg_a_no(en_reg_a_n), .en_reg_b_no(en_reg_b_n), .cntrl_alu_o(cntrl_alu),
        .result_i(dp_result), .carry_i(dp_carry),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_carry_o(rsp_carry),
        .busy_o(busy), .ops_done_o(ops_done)
    );

    alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1), .CNT_W(2)) dut_narrow (
        .clk_i(clk), .rst_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(n_cmd_ready),
        .cmd_op_a_i(cmd_op_a), .cmd_op_b_i(cmd_op_b), .cmd_alu_op_i(cmd_alu_op),
        .op_a_o(n_op_a), .op_b_o(n_op_b),
        .en_reg_a_no(n_en_a), .en_reg_b_no(n_en_b), .cntrl_alu_o(n_cntrl),
        .result_i(dp_result), .carry_i(dp_carry),
        .rsp_valid_o(n_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(n_rsp_result), .rsp_carry_o(n_rsp_carry),
        .busy_o(n_busy), .ops_done_o(n_ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath operand registers with active-low load enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a <= 4'h0;
            reg_b <= 4'h0;
        end else begin
            if (!en_reg_a_n) reg_a <= op_a;
            if (!en_reg_b_n) reg_b <= op_b;
        end
    end

    // Combinational ALU; SUB carry is the borrow out.
    always_comb begin
        {dp_carry, dp_result} = 5'h00;
        case (alu_op_e'(cntrl_alu))
            ALU_ADD: {dp_carry, dp_result} = {1'b0, reg_a} + {1'b0, reg_b};
            ALU_SUB: {dp_carry, dp_result} = {1'b0, reg_a} - {1'b0, reg_b};
            ALU_AND: {dp_carry, dp_result} = {1'b0, reg_a & reg_b};
            ALU_OR:  {dp_carry, dp_result} = {1'b0, reg_a | reg_b};
            default: {dp_carry, dp_result} = 5'h00;
        endcase
    end

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op_a = 4'h0; cmd_op_b = 4'h0;
        cmd_alu_op = 2'b00; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_count++;
        if ({en_reg_a_n, en_reg_b_n} !== 2'b11) begin
            error_count++; $display("FAIL reset_en: got %b want 11", {en_reg_a_n, en_reg_b_n});
        end
        check_count++;
        if ({op_a, op_b, cntrl_alu, rsp_result, rsp_carry, rsp_valid, busy} !== 15'h0) begin
            error_count++;
            $display("FAIL reset_outs: op_a=%h op_b=%h cntrl=%b res=%h c=%b v=%b busy=%b want all 0",
                     op_a, op_b, cntrl_alu, rsp_result, rsp_carry, rsp_valid, busy);
        end
        check_count++;
        if (ops_done !== 8'd0) begin
            error_count++; $display("FAIL reset_ops: got %0d want 0", ops_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_count++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            error_count++; $display("FAIL reset_release: ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_add();
        cmd_valid = 1'b1; cmd_op_a = 4'h9; cmd_op_b = 4'h8; cmd_alu_op = ALU_ADD; rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_count++;
        if ({en_reg_a_n, en_reg_b_n} !== 2'b00 || op_a !== 4'h9 || op_b !== 4'h8 || busy !== 1'b1) begin
            error_count++;
            $display("FAIL add_load: en=%b op_a=%h op_b=%h busy=%b want 00 9 8 1",
                     {en_reg_a_n, en_reg_b_n}, op_a, op_b, busy);
        end
        @(negedge clk);
        check_count++;
        if ({en_reg_a_n, en_reg_b_n} !== 2'b11 || rsp_valid !== 1'b0) begin
            error_count++;
            $display("FAIL add_settle: en=%b valid=%b want 11 0", {en_reg_a_n, en_reg_b_n}, rsp_valid);
        end
        @(negedge clk);
        check_count++;
        if (rsp_valid !== 1'b1 || rsp_result !== 4'h1 || rsp_carry !== 1'b1) begin
            error_count++;
            $display("FAIL add_rsp: valid=%b res=%h c=%b want 1 1 1", rsp_valid, rsp_result, rsp_carry);
        end
        @(negedge clk);
        check_count++;
        if (rsp_valid !== 1'b0 || ops_done !== 8'd1 || cmd_ready !== 1'b1) begin
            error_count++;
            $display("FAIL add_done: valid=%b ops=%0d ready=%b want 0 1 1", rsp_valid, ops_done, cmd_ready);
        end
    endtask

    task automatic test_sub_backpressure();
        cmd_valid = 1'b1; cmd_op_a = 4'h3; cmd_op_b = 4'h5; cmd_alu_op = ALU_SUB; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Offer a different command while the response is stalled; it must be ignored.
        cmd_valid = 1'b1; cmd_op_a = 4'hF; cmd_op_b = 4'hF; cmd_alu_op = ALU_OR;
        for (int i = 0; i < 5; i++) begin
            check_count++;
            if (rsp_valid !== 1'b1 || rsp_result !== 4'hE || rsp_carry !== 1'b1 ||
                cmd_ready !== 1'b0 || op_a !== 4'h3 || cntrl_alu !== 2'b01) begin
                error_count++;
                $display("FAIL sub_hold[%0d]: valid=%b res=%h c=%b ready=%b op_a=%h cntrl=%b want 1 e 1 0 3 01",
                         i, rsp_valid, rsp_result, rsp_carry, cmd_ready, op_a, cntrl_alu);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        check_count++;
        if (rsp_valid !== 1'b0 || ops_done !== 8'd2 || {en_reg_a_n, en_reg_b_n} !== 2'b11) begin
            error_count++;
            $display("FAIL sub_done: valid=%b ops=%0d en=%b want 0 2 11", rsp_valid, ops_done,
                     {en_reg_a_n, en_reg_b_n});
        end
    endtask

    task automatic test_back_to_back();
        logic exp_en_low;
        logic exp_valid;
        cmd_valid = 1'b1; cmd_op_a = 4'hC; cmd_op_b = 4'hA; cmd_alu_op = ALU_AND; rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_en_low = (k == 0) || (k == 4);
            exp_valid  = (k == 2) || (k == 6);
            check_count++;
            if (en_reg_a_n !== !exp_en_low || en_reg_b_n !== !exp_en_low || rsp_valid !== exp_valid) begin
                error_count++;
                $display("FAIL b2b_cycle[%0d]: en=%b valid=%b want en_low=%b valid=%b",
                         k, {en_reg_a_n, en_reg_b_n}, rsp_valid, exp_en_low, exp_valid);
            end
            if (k == 2) begin
                check_count++;
                if (rsp_result !== 4'h8 || rsp_carry !== 1'b0 || cntrl_alu !== 2'b10) begin
                    error_count++;
                    $display("FAIL b2b_and: res=%h c=%b cntrl=%b want 8 0 10", rsp_result, rsp_carry, cntrl_alu);
                end
            end
            if (k == 6) begin
                check_count++;
                if (rsp_result !== 4'hE || rsp_carry !== 1'b0 || cntrl_alu !== 2'b11) begin
                    error_count++;
                    $display("FAIL b2b_or: res=%h c=%b cntrl=%b want e 0 11", rsp_result, rsp_carry, cntrl_alu);
                end
            end
            if (k == 0) cmd_alu_op = ALU_OR;
            if (k == 4) cmd_valid = 1'b0;
        end
        check_count++;
        if (ops_done !== 8'd4) begin
            error_count++; $display("FAIL b2b_ops: got %0d want 4", ops_done);
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_op_a = 4'h9; cmd_op_b = 4'h8; cmd_alu_op = ALU_ADD; rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_count++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            error_count++; $display("FAIL mid_pre: busy=%b valid=%b want 1 0", busy, rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        check_count++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 8'd0 || op_a !== 4'h0 ||
            op_b !== 4'h0 || cntrl_alu !== 2'b00 || {en_reg_a_n, en_reg_b_n} !== 2'b11) begin
            error_count++;
            $display("FAIL mid_async: valid=%b busy=%b ops=%0d op_a=%h op_b=%h cntrl=%b en=%b want 0 0 0 0 0 00 11",
                     rsp_valid, busy, ops_done, op_a, op_b, cntrl_alu, {en_reg_a_n, en_reg_b_n});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_count++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || ops_done !== 8'd0) begin
                error_count++;
                $display("FAIL mid_after[%0d]: valid=%b ready=%b ops=%0d want 0 1 0",
                         i, rsp_valid, cmd_ready, ops_done);
            end
        end
    endtask

    task automatic test_counter_sat();
        logic [1:0] exp_narrow;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_op_a = 4'h1; cmd_op_b = 4'h2; cmd_alu_op = ALU_ADD;
            @(negedge clk);
            cmd_valid = 1'b0;
            repeat (3) @(negedge clk);
            exp_narrow = (i < 3) ? 2'(i + 1) : 2'd3;
            check_count++;
            if (ops_done !== 8'(i + 1) || n_ops_done !== exp_narrow) begin
                error_count++;
                $display("FAIL sat[%0d]: wide=%0d narrow=%0d want %0d %0d",
                         i, ops_done, n_ops_done, i + 1, exp_narrow);
            end
        end
    endtask

    initial begin
        error_count = 0;
        check_count = 0;
        test_reset();
        test_add();
        test_sub_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_counter_sat();
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
